pipe_stage_skid: RTL

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, flush, bubble injection and per-bit payload retention. It replaces the fixed-field stall/flush/bubble stage registers between pipeline stages (for example decode→execute), so back-pressure no longer needs a global combinational stall. It also keeps saturating stall, bubble and flush event counters for performance debug.

---
 rtl/pipe_stage_skid_if.sv | 12 +
 rtl/pipe_stage_skid.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/payload bundle for one side of a pipeline stage.
// The master drives valid and data; the slave drives ready.
interface pipe_stage_skid_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a two-entry skid buffer, flush, bubble injection and
// NOP merge that keeps masked payload bits; carries saturating stall/bubble/flush counters.
module pipe_stage_skid #(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] NOP_PAYLOAD = '0,
  parameter logic [WIDTH-1:0] KEEP_MASK   = '0,
  parameter int               CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_stage_skid_if.slave     up,
  pipe_stage_skid_if.master    dn,
  input  logic                 flush,
  input  logic                 bubble,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_p1;
  state_e           state_d;
  logic [WIDTH-1:0] main_data_p1;
  logic [WIDTH-1:0] main_data_d;
  logic [WIDTH-1:0] skid_data_p1;
  logic [WIDTH-1:0] skid_data_d;

  logic             out_valid;
  logic             skid_valid;
  logic             in_ready;
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] nop_val;

  logic             stall_ev;
  logic             bubble_ev;
  logic             flush_ev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             en);
    if (en && (cnt != {CNT_W{1'b1}}))
      return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    return cnt;
  endfunction

  function automatic logic [WIDTH-1:0] nop_merge(input logic [WIDTH-1:0] cur);
    return (cur & KEEP_MASK) | (NOP_PAYLOAD & ~KEEP_MASK);
  endfunction

  assign out_valid  = (state_p1 != EMPTY);
  assign skid_valid = (state_p1 == TWO);

  // Ready depends only on registered skid state plus flush/bubble, never on out_ready.
  assign in_ready  = !reset && !skid_valid && !flush && !bubble;
  assign accept    = up.valid && in_ready;
  assign drain     = out_valid && dn.ready;
  assign nop_val   = nop_merge(main_data_p1);

  assign up.ready  = in_ready;
  assign dn.valid  = out_valid;
  assign dn.data   = main_data_p1;
  assign occupancy = state_p1;

  assign stall_ev  = out_valid && !dn.ready && !flush;
  assign bubble_ev = bubble && !flush;
  assign flush_ev  = flush;

  always_comb begin
    state_d     = state_p1;
    main_data_d = main_data_p1;
    skid_data_d = skid_data_p1;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = nop_val;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = up.data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_data_d = up.data;
          end else if (accept) begin
            state_d     = TWO;
            skid_data_d = up.data;
          end else if (drain) begin
            state_d     = EMPTY;
            main_data_d = nop_val;
          end
        end
        TWO: begin
          if (drain) begin
            state_d     = ONE;
            main_data_d = skid_data_p1;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = nop_val;
        end
      endcase
    end
  end

  // Stage register: main/skid storage and occupancy state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1     <= EMPTY;
      main_data_p1 <= NOP_PAYLOAD;
      skid_data_p1 <= NOP_PAYLOAD;
    end else begin
      state_p1     <= state_d;
      main_data_p1 <= main_data_d;
      skid_data_p1 <= skid_data_d;
    end
  end

  // Event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_cnt  <= sat_inc(stall_cnt, stall_ev);
      bubble_cnt <= sat_inc(bubble_cnt, bubble_ev);
      flush_cnt  <= sat_inc(flush_cnt, flush_ev);
    end
  end

endmodule
